// File: rtl/instruction_fetch_controller_if.sv
// Bus bundle between the fetch controller, the instruction memory and the
// decode stage.
//   imem_chip_select / imem_address  : controller -> instruction memory
//   imem_instruction                 : instruction memory -> controller (combinational read data)
//   out_valid / out_instruction / out_pc : controller -> decode (buffer head)
//   out_ready                        : decode -> controller (head accepted this cycle)
// master = the fetch controller, slave = memory + decode side.
interface instruction_fetch_controller_if;
  logic        imem_chip_select;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  modport master (
    output imem_chip_select, imem_address, out_valid, out_instruction, out_pc,
    input  imem_instruction, out_ready
  );

  modport slave (
    input  imem_chip_select, imem_address, out_valid, out_instruction, out_pc,
    output imem_instruction, out_ready
  );
endinterface

// File: rtl/instruction_fetch_controller.sv
// Sequential instruction fetch controller.
// Issues reads from fetch_pc into the instruction memory, captures each
// {pc, instruction} pair into a 2-entry buffer and presents the head to
// decode over valid/ready. Supports redirect (flush + new PC), run enable,
// backpressure stall and a sticky out-of-range fault.
// Ports:
//   clk            : rising-edge clock
//   reset          : asynchronous active-high reset
//   enable         : 0 = issue no new reads (buffer still drains)
//   redirect_valid : load redirect_pc (word aligned) and flush the buffer
//   redirect_pc    : redirect target, bits [1:0] ignored
//   fault          : fetch PC out of range; held until redirect or reset
//   bus            : memory and decode handshake signals (master side)
module instruction_fetch_controller #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  instruction_fetch_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } entry_t;

  state_t      state;
  logic [31:0] fetch_pc;
  entry_t      head;       // oldest entry, drives out_*
  entry_t      tail;       // second entry when count == 2
  logic [1:0]  count;
  logic        head_valid;

  logic        pop;
  logic        push_ok;
  logic        in_range;
  logic        issue;
  logic [31:0] target;
  entry_t      new_entry;

  assign pop       = head_valid & bus.out_ready;
  assign push_ok   = (count < 2'd2) | pop;
  assign in_range  = fetch_pc < MEM_BYTES;
  assign issue     = (state == RUN) & enable & ~redirect_valid & push_ok & in_range;
  assign target    = redirect_pc & ~32'h3;
  assign new_entry = '{pc: fetch_pc, instruction: bus.imem_instruction};

  assign bus.imem_chip_select = issue;
  assign bus.imem_address     = fetch_pc;
  assign bus.out_valid        = head_valid;
  assign bus.out_instruction  = head.instruction;
  assign bus.out_pc           = head.pc;
  assign fault                = (state == FAULT);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      // NOTE: the buffer entries are reset (not left as uninitialised storage)
      // because out_instruction/out_pc must read 0 whenever it is empty.
      head       <= '0;
      tail       <= '0;
      count      <= 2'd0;
      head_valid <= 1'b0;
    end else begin
      // Control state: redirect outranks everything; FAULT is sticky otherwise.
      if (redirect_valid) begin
        if (!enable)                state <= IDLE;
        else if (target >= MEM_BYTES) state <= FAULT;
        else                        state <= RUN;
      end else begin
        case (state)
          IDLE:    if (enable) state <= RUN;
          RUN:     if (!enable) state <= IDLE;
                   else if (!in_range) state <= FAULT;
          FAULT:   ;
          default: state <= IDLE;
        endcase
      end

      if (redirect_valid)
        fetch_pc <= target;
      else if (issue)
        fetch_pc <= fetch_pc + 32'd4;

      // Buffer: empty slots are kept at zero so the head reads 0 when empty.
      if (redirect_valid) begin
        head       <= '0;
        tail       <= '0;
        count      <= 2'd0;
        head_valid <= 1'b0;
      end else begin
        case ({issue, pop})
          2'b11: begin
            // Retire head and append; occupancy unchanged.
            if (count == 2'd2) begin
              head <= tail;
              tail <= new_entry;
            end else begin
              head <= new_entry;
            end
          end
          2'b01: begin
            head       <= tail;
            tail       <= '0;
            count      <= count - 2'd1;
            head_valid <= (count == 2'd2);
          end
          2'b10: begin
            if (count == 2'd0) head <= new_entry;
            else               tail <= new_entry;
            count      <= count + 2'd1;
            head_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
